// File: rtl/lif_post_neuron_if.sv
// lif_post_neuron_if: current/tick inputs and spike/state outputs of the postsynaptic neuron
interface lif_post_neuron_if #(parameter int WIDTH = 32);
  logic signed [WIDTH-1:0] current_in;
  logic                    current_valid;
  logic                    tick;
  logic                    spike_out;
  logic [7:0]              spike_addr;
  logic signed [WIDTH-1:0] membrane;
  logic                    refractory;
  logic [15:0]             spike_count;
  modport master (
    output current_in, current_valid, tick,
    input  spike_out, spike_addr, membrane, refractory, spike_count
  );
  modport slave (
    input  current_in, current_valid, tick,
    output spike_out, spike_addr, membrane, refractory, spike_count
  );
endinterface

// File: rtl/lif_post_neuron.sv
// lif_post_neuron: leaky integrate-and-fire neuron with saturating membrane and refractory hold-off
module lif_post_neuron #(
  parameter int                      WIDTH         = 32,
  parameter logic signed [WIDTH-1:0] THRESHOLD     = 1000,
  parameter int                      LEAK_SHIFT    = 4,
  parameter logic signed [WIDTH-1:0] V_RESET       = 0,
  parameter int                      REFRACT_TICKS = 3,
  parameter logic [7:0]              NEURON_ADDR   = 8'd1
) (
  input logic             clk,
  input logic             rst_n,
  lif_post_neuron_if.slave bus
);
  typedef enum logic [1:0] {INTEGRATE, FIRE, REFRACT} state_t;
  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  state_t                  state;
  logic signed [WIDTH-1:0] v;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] addend;
  logic signed [WIDTH:0]   wide;
  logic signed [WIDTH-1:0] vn;
  logic [7:0]              cnt;
  logic                    spike;
  logic [7:0]              addr;
  logic                    refr;
  logic [15:0]             count;
  // Next potential: leak only on a tick (never overflows), then a saturating add of the current
  always_comb begin
    base   = bus.tick ? v - (v >>> LEAK_SHIFT) : v;
    addend = bus.current_valid ? bus.current_in : '0;
    wide   = {base[WIDTH-1], base} + {addend[WIDTH-1], addend};
    vn     = (wide[WIDTH] != wide[WIDTH-1]) ? (wide[WIDTH] ? MIN_V : MAX_V) : wide[WIDTH-1:0];
  end
  // Neuron FSM: integrate/leak, one-cycle fire, then tick-counted refractory hold-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INTEGRATE;
      v     <= V_RESET;
      cnt   <= '0;
      spike <= 1'b0;
      addr  <= '0;
      refr  <= 1'b0;
      count <= '0;
    end else begin
      spike <= 1'b0;
      addr  <= '0;
      case (state)
        INTEGRATE: begin
          if (bus.tick) begin
            v <= vn;
            if (vn >= THRESHOLD) begin
              state <= FIRE;
              spike <= 1'b1;
              addr  <= NEURON_ADDR;
              count <= count + 16'd1;
            end
          end else if (bus.current_valid) v <= vn;
        end
        FIRE: begin
          v     <= V_RESET;
          cnt   <= 8'(REFRACT_TICKS);
          refr  <= REFRACT_TICKS != 0;
          state <= REFRACT_TICKS != 0 ? REFRACT : INTEGRATE;
        end
        REFRACT: begin
          if (bus.tick) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state <= INTEGRATE;
              refr  <= 1'b0;
            end
          end
        end
        default: state <= INTEGRATE;
      endcase
    end
  end
  assign bus.membrane    = v;
  assign bus.spike_out   = spike;
  assign bus.spike_addr  = addr;
  assign bus.refractory  = refr;
  assign bus.spike_count = count;
endmodule

// File: tb/tb_lif_post_neuron.sv
// tb_lif_post_neuron: directed scoreboard bench for the LIF neuron
module tb_lif_post_neuron;
  typedef struct {
    logic signed [31:0] v;
    logic               spike;
    logic [7:0]         addr;
    logic               refr;
    logic [15:0]        cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int                 m_st;
  logic signed [31:0] m_v;
  int                 m_rc;
  logic               m_spk;
  logic               m_refr;
  logic [15:0]        m_cnt;
  lif_post_neuron_if #(.WIDTH(32)) ifc ();
  lif_post_neuron #(
    .WIDTH(32), .THRESHOLD(1000), .LEAK_SHIFT(4), .V_RESET(0),
    .REFRACT_TICKS(3), .NEURON_ADDR(8'd1)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  always #5 clk = ~clk;
  function automatic logic signed [31:0] msat(longint x);
    if (x > 64'sd2147483647) return 32'sh7FFFFFFF;
    if (x < -64'sd2147483648) return 32'sh80000000;
    return 32'(x);
  endfunction
  task automatic model_reset();
    m_st = 0; m_v = 0; m_rc = 0; m_spk = 0; m_refr = 0; m_cnt = 0;
  endtask
  task automatic model_step(logic cv, logic signed [31:0] cur, logic tk);
    longint s;
    m_spk = 0;
    if (m_st == 0) begin
      if (tk) begin
        s = longint'(m_v) - longint'(m_v >>> 4) + (cv ? longint'(cur) : 64'sd0);
        m_v = msat(s);
        if (m_v >= 1000) begin
          m_st = 1; m_spk = 1; m_cnt = m_cnt + 16'd1;
        end
      end else if (cv) m_v = msat(longint'(m_v) + longint'(cur));
    end else if (m_st == 1) begin
      m_v = 0; m_st = 2; m_rc = 3; m_refr = 1;
    end else if (tk) begin
      if (m_rc == 1) begin
        m_st = 0; m_refr = 0;
      end
      m_rc = m_rc - 1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic step(logic cv, logic signed [31:0] cur, logic tk);
    exp_t e;
    ifc.current_valid = cv;
    ifc.current_in    = cur;
    ifc.tick          = tk;
    model_step(cv, cur, tk);
    q.push_back('{m_v, m_spk, m_spk ? 8'd1 : 8'd0, m_refr, m_cnt});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("membrane", ifc.membrane, e.v);
    chk("spike_out", 32'(ifc.spike_out), 32'(e.spike));
    chk("spike_addr", 32'(ifc.spike_addr), 32'(e.addr));
    chk("refractory", 32'(ifc.refractory), 32'(e.refr));
    chk("spike_count", 32'(ifc.spike_count), 32'(e.cnt));
    ifc.current_valid = 1'b0;
    ifc.tick          = 1'b0;
  endtask
  initial begin
    model_reset();
    ifc.current_valid = 1'b1;
    ifc.current_in    = 500;
    ifc.tick          = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_membrane", ifc.membrane, 32'd0);
    chk("rst_spike", 32'(ifc.spike_out), 32'd0);
    chk("rst_addr", 32'(ifc.spike_addr), 32'd0);
    chk("rst_refr", 32'(ifc.refractory), 32'd0);
    chk("rst_count", 32'(ifc.spike_count), 32'd0);
    rst_n = 1'b1;
    step(1, 300, 0);
    chk("first_current", ifc.membrane, 32'd300);
    step(1, 300, 0);
    step(1, 300, 0);
    chk("integrate_900", ifc.membrane, 32'd900);
    step(1, 200, 1);
    chk("cross_1044", ifc.membrane, 32'd1044);
    chk("fire_spike", 32'(ifc.spike_out), 32'd1);
    chk("fire_addr", 32'(ifc.spike_addr), 32'd1);
    chk("fire_count", 32'(ifc.spike_count), 32'd1);
    step(0, 0, 0);
    chk("post_fire_v", ifc.membrane, 32'd0);
    chk("post_fire_refr", 32'(ifc.refractory), 32'd1);
    step(1, 5000, 1);
    step(1, 5000, 0);
    step(1, 5000, 1);
    chk("refr_still", 32'(ifc.refractory), 32'd1);
    step(1, 5000, 1);
    chk("refr_exit", 32'(ifc.refractory), 32'd0);
    chk("refr_v_held", ifc.membrane, 32'd0);
    step(1, 100, 0);
    chk("after_refr_100", ifc.membrane, 32'd100);
    step(1, -260, 0);
    step(0, 0, 1);
    chk("neg_leak", ifc.membrane, 32'hFFFFFF6A);
    step(1, 149, 0);
    chk("v_minus1", ifc.membrane, 32'hFFFFFFFF);
    step(0, 0, 1);
    step(1, 32'h7FFFFF00, 0);
    step(1, 32'h1000, 0);
    chk("pos_sat", ifc.membrane, 32'h7FFFFFFF);
    step(1, -32'sh7FFFFFFF, 0);
    step(1, 999, 1);
    chk("same_cycle_999", ifc.membrane, 32'd999);
    chk("same_cycle_nospike", 32'(ifc.spike_out), 32'd0);
    step(0, 0, 1);
    chk("leak_937", ifc.membrane, 32'd937);
    step(1, 32'sh80000000, 0);
    step(1, 32'sh80000000, 0);
    chk("neg_sat", ifc.membrane, 32'h80000000);
    step(1, 32'sh7FFFFFFF, 0);
    step(1, 1, 0);
    step(1, 2000, 1);
    chk("second_spike", 32'(ifc.spike_count), 32'd2);
    step(0, 0, 0);
    step(0, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_refr", 32'(ifc.refractory), 32'd0);
    chk("async_v", ifc.membrane, 32'd0);
    chk("async_count", 32'(ifc.spike_count), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1);
    chk("post_rst_nospike", 32'(ifc.spike_out), 32'd0);
    step(0, 0, 0);
    chk("post_rst_count", 32'(ifc.spike_count), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
